// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access kinds seen by the checker and the check-arbiter FSM states.
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACCESS_NONE      = 2'b00,
        ACCESS_READ      = 2'b01,
        ACCESS_WRITE     = 2'b10,
        ACCESS_EXECUTION = 2'b11
    } access_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        RESP  = 2'b10
    } arb_state_e;

    // Index width that stays legal (>=1 bit) even for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_iopmp_rr_select.sv
// Combinational round-robin find-first: first valid requester at or above the pointer, wrapping.
module rv_iopmp_rr_select
    import rv_iopmp_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Offset i is the distance from the pointer; the first hit wins.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!o_any && i_valid[j] && (j == (i + 32'(i_ptr)) % NUM_REQ)) begin
                    o_any      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/rv_iopmp_check_arbiter.sv
// Round-robin arbiter sharing one IOPMP transaction checker among NUM_REQ requesters.
// Accepted requests are registered, checked for CHECK_LATENCY+1 cycles, then answered with a one-cycle verdict pulse.
module rv_iopmp_check_arbiter
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned NB_WIDTH      = 4,
    parameter int unsigned SID_WIDTH     = 1,
    parameter int unsigned CHECK_LATENCY = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*NB_WIDTH-1:0]    req_num_bytes_i,
    input  logic [NUM_REQ*SID_WIDTH-1:0]   req_sid_i,
    input  access_t [NUM_REQ-1:0]          req_access_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [NUM_REQ-1:0]             rsp_allow_o,
    output logic                           transaction_en_o,
    output logic [ADDR_WIDTH-1:0]          addr_o,
    output logic [NB_WIDTH-1:0]            num_bytes_o,
    output logic [SID_WIDTH-1:0]           sid_o,
    output access_t                        access_type_o,
    input  logic                           allow_transaction_i
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(CHECK_LATENCY + 1) + 1;

    arb_state_e            r_state;
    arb_state_e            w_state_next;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_any;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_cnt_done;
    logic                  r_verdict;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NB_WIDTH-1:0]   r_num_bytes;
    logic [SID_WIDTH-1:0]  r_sid;
    access_t               r_access;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [NB_WIDTH-1:0]   w_sel_num_bytes;
    logic [SID_WIDTH-1:0]  w_sel_sid;
    access_t               w_sel_access;

    rv_iopmp_rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_select (
        .i_valid(req_valid_i),
        .i_ptr  (r_ptr),
        .o_grant(w_grant),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // With a single requester r_idx is always 0, so the pointer stays tied to 0.
    assign w_ptr_next = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_cnt_done = (r_cnt == CNT_W'(CHECK_LATENCY));

    always_comb begin
        w_sel_addr      = '0;
        w_sel_num_bytes = '0;
        w_sel_sid       = '0;
        w_sel_access    = ACCESS_NONE;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) begin
                w_sel_addr      = req_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_num_bytes = req_num_bytes_i[j*NB_WIDTH +: NB_WIDTH];
                w_sel_sid       = req_sid_i[j*SID_WIDTH +: SID_WIDTH];
                w_sel_access    = req_access_i[j];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = CHECK;
            CHECK:   if (w_cnt_done) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_verdict   <= 1'b0;
            r_addr      <= '0;
            r_num_bytes <= '0;
            r_sid       <= '0;
            r_access    <= ACCESS_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx       <= w_idx;
                        r_cnt       <= '0;
                        r_addr      <= w_sel_addr;
                        r_num_bytes <= w_sel_num_bytes;
                        r_sid       <= w_sel_sid;
                        r_access    <= w_sel_access;
                    end
                end
                CHECK: begin
                    if (w_cnt_done) begin
                        r_verdict <= allow_transaction_i;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP:    r_ptr <= w_ptr_next;
                default: ;
            endcase
        end
    end

    // Ready is gated by reset so a held request is never signalled as accepted while in reset.
    assign req_ready_o      = (r_state == IDLE && rst_ni) ? w_grant : '0;
    assign transaction_en_o = (r_state == CHECK);
    assign addr_o           = r_addr;
    assign num_bytes_o      = r_num_bytes;
    assign sid_o            = r_sid;
    assign access_type_o    = r_access;

    always_comb begin
        rsp_valid_o = '0;
        rsp_allow_o = '0;
        if (r_state == RESP) begin
            rsp_valid_o[r_idx] = 1'b1;
            rsp_allow_o[r_idx] = r_verdict;
        end
    end

endmodule

// File: tb/tb_rv_iopmp_check_arbiter.sv
// Bench for rv_iopmp_check_arbiter: two DUTs (latency 0 and 3) checked every cycle against a timeline model.
module tb_rv_iopmp_check_arbiter
    import rv_iopmp_pkg::*;
;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Index 0 drives the CHECK_LATENCY=0 instance, index 1 the CHECK_LATENCY=3 instance.
    logic [1:0]    valid [2];
    logic [127:0]  addr  [2];
    logic [7:0]    nb    [2];
    logic [1:0]    sid   [2];
    access_t [1:0] acc   [2];
    logic          allow [2];

    logic [1:0]    ready  [2];
    logic [1:0]    rspv   [2];
    logic [1:0]    rspa   [2];
    logic          en     [2];
    logic [63:0]   addr_o [2];
    logic [3:0]    nb_o   [2];
    logic          sid_o  [2];
    access_t       acc_o  [2];

    rv_iopmp_check_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(64), .NB_WIDTH(4), .SID_WIDTH(1), .CHECK_LATENCY(0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(valid[0]), .req_ready_o(ready[0]),
        .req_addr_i(addr[0]), .req_num_bytes_i(nb[0]), .req_sid_i(sid[0]), .req_access_i(acc[0]),
        .rsp_valid_o(rspv[0]), .rsp_allow_o(rspa[0]),
        .transaction_en_o(en[0]), .addr_o(addr_o[0]), .num_bytes_o(nb_o[0]), .sid_o(sid_o[0]),
        .access_type_o(acc_o[0]), .allow_transaction_i(allow[0])
    );

    rv_iopmp_check_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(64), .NB_WIDTH(4), .SID_WIDTH(1), .CHECK_LATENCY(3)
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(valid[1]), .req_ready_o(ready[1]),
        .req_addr_i(addr[1]), .req_num_bytes_i(nb[1]), .req_sid_i(sid[1]), .req_access_i(acc[1]),
        .rsp_valid_o(rspv[1]), .rsp_allow_o(rspa[1]),
        .transaction_en_o(en[1]), .addr_o(addr_o[1]), .num_bytes_o(nb_o[1]), .sid_o(sid_o[1]),
        .access_type_o(acc_o[1]), .allow_transaction_i(allow[1])
    );

    task automatic check(input string name, input bit d, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h required 0x%0h at %0t", name, d, got, exp, $time);
        end
    endtask

    // Model: each accepted request occupies a timeline; k counts cycles since acceptance.
    bit          m_busy    [2];
    int          m_k       [2];
    int          m_idx     [2];
    int          m_ptr     [2];
    logic        m_verdict [2];
    logic [63:0] m_addr    [2];
    logic [3:0]  m_nb      [2];
    logic        m_sid     [2];
    access_t     m_acc     [2];

    function automatic int lat(input bit d);
        return d ? 3 : 0;
    endfunction

    function automatic int winner(input logic [1:0] v, input int p);
        for (int i = 0; i < 2; i++) begin
            int c;
            c = (p + i) % 2;
            if (v[c[0]]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_k[i] = 0; m_idx[i] = 0; m_ptr[i] = 0; m_verdict[i] = 1'b0;
            m_addr[i] = '0; m_nb[i] = '0; m_sid[i] = 1'b0; m_acc[i] = ACCESS_NONE;
        end
    endtask

    bit         dd_c;
    int         w_c;
    logic [1:0] e_ready, e_rspv, e_rspa;
    logic       e_en;

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        for (int i = 0; i < 2; i++) begin
            dd_c = i[0];
            e_ready = '0; e_rspv = '0; e_rspa = '0; e_en = 1'b0;
            if (rst_n) begin
                if (!m_busy[dd_c]) begin
                    w_c = winner(valid[dd_c], m_ptr[dd_c]);
                    if (w_c >= 0) e_ready = 2'b01 << w_c;
                end else if (m_k[dd_c] <= lat(dd_c) + 1) begin
                    e_en = 1'b1;
                end else begin
                    e_rspv = 2'b01 << m_idx[dd_c];
                    e_rspa = {1'b0, m_verdict[dd_c]} << m_idx[dd_c];
                end
            end
            check("model.ready",   dd_c, 64'(ready[dd_c]),  64'(e_ready));
            check("model.en",      dd_c, 64'(en[dd_c]),     64'(e_en));
            check("model.addr",    dd_c, addr_o[dd_c],      m_addr[dd_c]);
            check("model.nbytes",  dd_c, 64'(nb_o[dd_c]),   64'(m_nb[dd_c]));
            check("model.sid",     dd_c, 64'(sid_o[dd_c]),  64'(m_sid[dd_c]));
            check("model.access",  dd_c, 64'(acc_o[dd_c]),  64'(m_acc[dd_c]));
            check("model.rspv",    dd_c, 64'(rspv[dd_c]),   64'(e_rspv));
            check("model.rspa",    dd_c, 64'(rspa[dd_c]),   64'(e_rspa));
        end
    end

    bit dd_u;
    int w_u;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                dd_u = i[0];
                if (!m_busy[dd_u]) begin
                    w_u = winner(valid[dd_u], m_ptr[dd_u]);
                    if (w_u >= 0) begin
                        m_busy[dd_u] = 1'b1;
                        m_k[dd_u]    = 1;
                        m_idx[dd_u]  = w_u;
                        m_addr[dd_u] = (w_u == 0) ? addr[dd_u][63:0] : addr[dd_u][127:64];
                        m_nb[dd_u]   = (w_u == 0) ? nb[dd_u][3:0]    : nb[dd_u][7:4];
                        m_sid[dd_u]  = (w_u == 0) ? sid[dd_u][0]     : sid[dd_u][1];
                        m_acc[dd_u]  = (w_u == 0) ? acc[dd_u][0]     : acc[dd_u][1];
                    end
                end else if (m_k[dd_u] == lat(dd_u) + 2) begin
                    m_busy[dd_u] = 1'b0;
                    m_ptr[dd_u]  = (m_idx[dd_u] + 1) % 2;
                end else begin
                    if (m_k[dd_u] == lat(dd_u) + 1) m_verdict[dd_u] = allow[dd_u];
                    m_k[dd_u] = m_k[dd_u] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input bit d, input bit r, input logic [63:0] a, input logic [3:0] n,
                           input logic s, input access_t t);
        if (r) begin
            addr[d][127:64] = a; nb[d][7:4] = n; sid[d][1] = s; acc[d][1] = t;
        end else begin
            addr[d][63:0] = a; nb[d][3:0] = n; sid[d][0] = s; acc[d][0] = t;
        end
        valid[d][r] = 1'b1;
    endtask

    task automatic wait_ready(input bit d, input bit r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = ready[d][r];
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_ready dut%0d req%0d: got no ready required ready within 20 cycles", d, r);
        end
    endtask

    int order [$];
    int encnt, rcount;
    bit stable;

    initial begin
        for (int i = 0; i < 2; i++) begin
            valid[i] = '0; addr[i] = '0; nb[i] = '0; sid[i] = '0;
            acc[i] = {ACCESS_NONE, ACCESS_NONE}; allow[i] = 1'b1;
        end

        // Reset with both requesters pending
        present(1'b0, 1'b0, 64'h10, 4'd1, 1'b0, ACCESS_READ);
        present(1'b0, 1'b1, 64'h20, 4'd2, 1'b1, ACCESS_WRITE);
        present(1'b1, 1'b0, 64'h30, 4'd3, 1'b0, ACCESS_READ);
        present(1'b1, 1'b1, 64'h40, 4'd4, 1'b1, ACCESS_WRITE);
        repeat (2) @(negedge clk);
        check("rst.ready", 1'b0, 64'(ready[0]), 64'h0);
        check("rst.ready", 1'b1, 64'(ready[1]), 64'h0);
        check("rst.en",    1'b0, 64'(en[0]),    64'h0);
        check("rst.rspv",  1'b0, 64'(rspv[0]),  64'h0);
        check("rst.addr",  1'b0, addr_o[0],     64'h0);
        check("rst.access", 1'b1, 64'(acc_o[1]), 64'(ACCESS_NONE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.grant0", 1'b0, 64'(ready[0]), 64'h1);
        check("rst.grant0", 1'b1, 64'(ready[1]), 64'h1);
        tick();
        valid[0] = '0; valid[1] = '0;
        repeat (8) tick();

        // Single request on the latency-0 instance
        present(1'b0, 1'b0, 64'h8000_1000, 4'd8, 1'b1, ACCESS_WRITE);
        allow[0] = 1'b1;
        @(negedge clk);
        check("s2.ready", 1'b0, 64'(ready[0]), 64'h1);
        tick();
        valid[0] = '0;
        @(negedge clk);
        check("s2.en",     1'b0, 64'(en[0]),    64'h1);
        check("s2.addr",   1'b0, addr_o[0],     64'h8000_1000);
        check("s2.nbytes", 1'b0, 64'(nb_o[0]),  64'd8);
        check("s2.sid",    1'b0, 64'(sid_o[0]), 64'h1);
        check("s2.access", 1'b0, 64'(acc_o[0]), 64'(ACCESS_WRITE));
        @(negedge clk);
        check("s2.rspv", 1'b0, 64'(rspv[0]), 64'h1);
        check("s2.rspa", 1'b0, 64'(rspa[0]), 64'h1);
        tick();

        // Return pointers to 0 before the fairness run
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Both requesters continuously valid
        present(1'b0, 1'b0, 64'hA000, 4'd4, 1'b0, ACCESS_READ);
        present(1'b0, 1'b1, 64'hB000, 4'd2, 1'b1, ACCESS_WRITE);
        for (int i = 0; i < 60 && order.size() < 6; i++) begin
            @(negedge clk);
            if (ready[0] != 2'b00) order.push_back(ready[0][1] ? 1 : 0);
            allow[0] = ~allow[0];
        end
        tick();
        valid[0] = '0;
        check("s3.grants", 1'b0, 64'(order.size()), 64'd6);
        for (int i = 0; i < order.size(); i++) check("s3.order", 1'b0, 64'(order[i]), 64'(i % 2));
        repeat (4) tick();

        // req1 raised while req0 is being checked
        allow[0] = 1'b0;
        present(1'b0, 1'b0, 64'hC000, 4'd1, 1'b0, ACCESS_READ);
        wait_ready(1'b0, 1'b0);
        tick();
        valid[0] = 2'b00;
        present(1'b0, 1'b1, 64'hD000, 4'd2, 1'b1, ACCESS_WRITE);
        @(negedge clk);
        check("s5.check_ready", 1'b0, 64'(ready[0]), 64'h0);
        @(negedge clk);
        check("s5.resp_ready",  1'b0, 64'(ready[0]), 64'h0);
        @(negedge clk);
        check("s5.idle_ready",  1'b0, 64'(ready[0]), 64'h2);
        tick();
        valid[0] = '0;
        repeat (4) tick();

        // Latency-3 instance: only the last check-cycle verdict counts
        present(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 4'd4, 1'b0, ACCESS_READ);
        allow[1] = 1'b1;
        wait_ready(1'b1, 1'b0);
        tick();
        valid[1] = '0;
        allow[1] = 1'b1;
        encnt = 0;
        stable = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (en[1]) encnt++;
            if (addr_o[1] !== 64'h1234_5678_9ABC_DEF0) stable = 1'b0;
            tick();
            allow[1] = (c == 3) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        check("s4.rspv",    1'b1, 64'(rspv[1]), 64'h1);
        check("s4.rspa",    1'b1, 64'(rspa[1]), 64'h0);
        check("s4.en_off",  1'b1, 64'(en[1]),   64'h0);
        check("s4.en_cycles", 1'b1, 64'(encnt), 64'd4);
        check("s4.payload_stable", 1'b1, 64'(stable), 64'h1);
        repeat (3) tick();

        // Reset during the second check cycle drops the in-flight check
        present(1'b1, 1'b1, 64'hFEED_0000, 4'd8, 1'b1, ACCESS_WRITE);
        wait_ready(1'b1, 1'b1);
        tick();
        valid[1] = '0;
        tick();
        rst_n = 1'b0;
        valid[1] = 2'b10;
        rcount = 0;
        repeat (3) begin
            @(negedge clk);
            rcount += $countones(rspv[1]);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("s6.no_rsp",  1'b1, 64'(rcount),   64'd0);
        check("s6.regrant", 1'b1, 64'(ready[1]), 64'h2);
        tick();
        valid[1] = '0;
        rcount = 0;
        repeat (7) begin
            @(negedge clk);
            rcount += $countones(rspv[1]);
        end
        check("s6.one_rsp", 1'b1, 64'(rcount), 64'd1);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test required finish before 100000 time units");
        $fatal(1);
    end

endmodule
